// File: rtl/stego_pkg.sv
// stego_pkg: shared constants and FSM state type for the LSB steganography embedder
package stego_pkg;
  localparam int CT_W = 64;
  localparam int PIX_W_DEF = 8;
  localparam int LSB_BITS_DEF = 1;
  typedef enum logic {IDLE, EMBED} state_t;
endpackage

// File: rtl/lsb_merge.sv
// lsb_merge: replaces the low LSB_BITS of a cover pixel with ciphertext bits
module lsb_merge
  import stego_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LSB_BITS = LSB_BITS_DEF
) (
  input  logic [PIX_W-1:0]    pix,
  input  logic [LSB_BITS-1:0] bits,
  output logic [PIX_W-1:0]    merged
);
  localparam logic [PIX_W-1:0] MASK = PIX_W'((1 << LSB_BITS) - 1);
  assign merged = (pix & ~MASK) | PIX_W'(bits);
endmodule

// File: rtl/stego_lsb_embed.sv
// stego_lsb_embed: embeds a 64-bit ciphertext block into the LSBs of a cover pixel stream
module stego_lsb_embed
  import stego_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LSB_BITS = LSB_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CT_W-1:0]  ct_data,
  input  logic             ct_valid,
  output logic             ct_ready,
  input  logic [PIX_W-1:0] pix_in_data,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [PIX_W-1:0] pix_out_data,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic             pix_out_last,
  output logic             busy,
  output logic [15:0]      blocks_done
);
  localparam int N = CT_W / LSB_BITS;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  state_t state_q, state_d;
  logic [CT_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] out_q, out_d, merged;
  logic ov_q, ov_d, last_q, last_d;
  logic [15:0] blk_q, blk_d;
  logic pix_fire, ct_fire, last_pix;
  lsb_merge #(.PIX_W(PIX_W), .LSB_BITS(LSB_BITS)) u_merge (
    .pix   (pix_in_data),
    .bits  (sr_q[CT_W-1 -: LSB_BITS]),
    .merged(merged)
  );
  always_comb begin
    last_pix = cnt_q == CNT_LAST;
    pix_in_ready = !rst && state_q == EMBED && (!ov_q || pix_out_ready);
    pix_fire = pix_in_valid && pix_in_ready;
    // accepting the final pixel frees the shift register in the same cycle
    ct_ready = !rst && (state_q == IDLE || (pix_fire && last_pix));
    ct_fire = ct_valid && ct_ready;
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    if (pix_fire) begin
      sr_d = sr_q << LSB_BITS;
      cnt_d = last_pix ? '0 : cnt_q + 1'b1;
      state_d = last_pix ? IDLE : state_q;
    end
    if (ct_fire) begin
      sr_d = ct_data;
      cnt_d = '0;
      state_d = EMBED;
    end
    out_d = pix_fire ? merged : out_q;
    ov_d = pix_fire || (ov_q && !pix_out_ready);
    last_d = pix_fire ? last_pix : (ov_d && last_q);
    blk_d = blk_q + 16'(ov_q && pix_out_ready && last_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ov_q <= 1'b0;
      last_q <= 1'b0;
      blk_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ov_q <= ov_d;
      last_q <= last_d;
      blk_q <= blk_d;
    end
  end
  assign pix_out_data = out_q;
  assign pix_out_valid = ov_q;
  assign pix_out_last = last_q;
  assign busy = state_q == EMBED;
  assign blocks_done = blk_q;
endmodule

// File: tb/tb_stego_lsb_embed.sv
// tb_stego_lsb_embed: directed and random stimulus checked against a stream-level model
module tb_stego_lsb_embed;
  localparam int L = 1;
  localparam int N = 64 / L;
  localparam logic [7:0] MASK = 8'((1 << L) - 1);
  logic clk = 0, rst = 1;
  logic [63:0] ct_data = '0;
  logic ct_valid = 0, ct_ready;
  logic [7:0] pix_in_data = '0, pix_out_data;
  logic pix_in_valid = 0, pix_in_ready, pix_out_valid, pix_out_ready = 1, pix_out_last, busy;
  logic [15:0] blocks_done;
  logic [63:0] ct2_data = '0;
  logic ct2_valid = 0, ct2_ready, pix2_valid = 0, pix2_ready, d2_ov, d2_last, d2_busy;
  logic [7:0] pix2_data = '0, d2_out;
  logic [15:0] d2_blocks;
  int n_tests = 0, n_fail = 0, cyc = 0;
  typedef struct packed {logic [7:0] d; logic l;} ent_t;
  ent_t expq[$];
  logic [7:0] cap_d[$];
  logic cap_l[$];
  int cap_c[$];
  logic have = 0;
  int idx = 0;
  logic [63:0] cur = '0;
  logic [15:0] mb = '0;
  logic prev_stall = 0, prev_l = 0;
  logic [7:0] prev_d = '0;

  stego_lsb_embed dut (
    .clk(clk), .rst(rst), .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .pix_in_data(pix_in_data), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .pix_out_data(pix_out_data), .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
    .pix_out_last(pix_out_last), .busy(busy), .blocks_done(blocks_done)
  );
  stego_lsb_embed #(.PIX_W(8), .LSB_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .ct_data(ct2_data), .ct_valid(ct2_valid), .ct_ready(ct2_ready),
    .pix_in_data(pix2_data), .pix_in_valid(pix2_valid), .pix_in_ready(pix2_ready),
    .pix_out_data(d2_out), .pix_out_valid(d2_ov), .pix_out_ready(1'b1),
    .pix_out_last(d2_last), .busy(d2_busy), .blocks_done(d2_blocks)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    logic exp_ov, exp_pir, pfire, lastp, exp_ctr;
    logic [7:0] bits;
    cyc++;
    if (rst) begin
      chk("rst_ct_ready", ct_ready, 0);
      chk("rst_pix_in_ready", pix_in_ready, 0);
      chk("rst_out", {pix_out_valid, pix_out_last, pix_out_data}, 0);
      chk("rst_busy_blocks", {busy, blocks_done}, 0);
      expq.delete(); cap_d.delete(); cap_l.delete(); cap_c.delete();
      have = 0; idx = 0; mb = 0; prev_stall = 0;
    end else begin
      exp_ov = expq.size() != 0;
      chk("out_valid", pix_out_valid, exp_ov);
      chk("blocks_done", blocks_done, mb);
      chk("busy", busy, have);
      exp_pir = have && (!exp_ov || pix_out_ready);
      chk("pix_in_ready", pix_in_ready, exp_pir);
      pfire = pix_in_valid && exp_pir;
      lastp = have && idx == N - 1;
      exp_ctr = !have || (pfire && lastp);
      chk("ct_ready", ct_ready, exp_ctr);
      if (prev_stall) chk("stall_stable", {pix_out_valid, pix_out_last, pix_out_data}, {1'b1, prev_l, prev_d});
      if (exp_ov) begin
        chk("out_data", pix_out_data, expq[0].d);
        chk("out_last", pix_out_last, expq[0].l);
        if (pix_out_ready) begin
          cap_d.push_back(pix_out_data); cap_l.push_back(pix_out_last); cap_c.push_back(cyc);
          if (expq[0].l) mb = mb + 16'd1;
          void'(expq.pop_front());
        end
      end
      prev_stall = exp_ov && !pix_out_ready;
      prev_d = pix_out_data; prev_l = pix_out_last;
      if (pfire) begin
        bits = 8'((cur >> (64 - L * (idx + 1))) & 64'(MASK));
        expq.push_back('{d: (pix_in_data & ~MASK) | bits, l: lastp});
        idx++;
        if (lastp) begin have = 0; idx = 0; end
      end
      if (ct_valid && exp_ctr) begin cur = ct_data; have = 1; idx = 0; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; ct_valid = 0; pix_in_valid = 0; pix_out_ready = 1; ct2_valid = 0; pix2_valid = 0;
    step(); step();
    rst = 0;
    step();
    chk("post_rst_ct_ready", ct_ready, 1);
  endtask

  task automatic stream(input logic [63:0] c0, input logic [63:0] c1, input int nblk, input int npix,
                        input logic [7:0] pix, input int stall_at, input int stall_len);
    int acc = 0, sent = 0, guard = 0, st_left = 0;
    bit trig = 0;
    while (sent < npix && guard < 2000) begin
      ct_data = acc == 0 ? c0 : c1;
      ct_valid = acc < nblk;
      pix_in_valid = 1; pix_in_data = pix;
      if (sent == stall_at && !trig) begin trig = 1; st_left = stall_len; end
      if (st_left > 0) begin pix_out_ready = 0; st_left--; end else pix_out_ready = 1;
      @(negedge clk);
      if (ct_valid && ct_ready) acc++;
      if (pix_in_valid && pix_in_ready) sent++;
      step();
      guard++;
    end
    chk("stream_sent", sent, npix);
    ct_valid = 0; pix_in_valid = 0; pix_out_ready = 1;
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  initial begin
    logic [7:0] lsb_exp;
    logic [7:0] d2[$];
    logic l2[$];
    int g;
    do_reset();
    // all-zero ciphertext into white pixels
    stream(64'h0, 64'h0, 1, 64, 8'hFF, -1, 0);
    drain();
    chk("s35_n", cap_d.size(), 64);
    for (int i = 0; i < cap_d.size(); i++) begin
      chk("s35_data", cap_d[i], 8'hFE);
      chk("s35_last", cap_l[i], i == 63);
    end
    chk("s35_blocks", blocks_done, 1);
    do_reset();
    stream(64'h8000000000000001, 64'h0, 1, 64, 8'h00, -1, 0);
    drain();
    chk("s36_n", cap_d.size(), 64);
    if (cap_d.size() == 64) begin
      chk("s36_first", cap_d[0], 8'h01);
      for (int i = 1; i < 63; i++) chk("s36_mid", cap_d[i], 8'h00);
      chk("s36_lastd", {cap_l[63], cap_d[63]}, 9'h101);
      chk("s36_nolast", cap_l[62], 0);
    end
    do_reset();
    stream(64'h85ABCD1A98876543, 64'h0, 1, 64, 8'hAA, 11, 5);
    drain();
    chk("s37_n", cap_d.size(), 64);
    lsb_exp = 8'b10000101;
    if (cap_d.size() >= 8)
      for (int i = 0; i < 8; i++) chk("s37_lsb", cap_d[i], {7'b1010101, lsb_exp[7 - i]});
    do_reset();
    stream(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2, 128, 8'h3C, -1, 0);
    drain();
    chk("s38_n", cap_d.size(), 128);
    if (cap_d.size() == 128) begin
      chk("s38_last1", cap_l[63], 1);
      chk("s38_nobubble", cap_c[64] - cap_c[63], 1);
      chk("s38_first2", cap_d[64], 8'h3D);
    end
    chk("s38_blocks", blocks_done, 2);
    do_reset();
    stream(64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 11, 8'h55, -1, 0);
    rst = 1; step(); step(); rst = 0; step();
    chk("s39_out", {pix_out_valid, pix_out_data}, 0);
    chk("s39_blocks", blocks_done, 0);
    stream(64'h8000000000000001, 64'h0, 1, 64, 8'h00, -1, 0);
    drain();
    chk("s39_n", cap_d.size(), 64);
    if (cap_d.size() > 1) chk("s39_first", cap_d[0], 8'h01);
    do_reset();
    ct2_data = 64'hC000000000000000; ct2_valid = 1;
    step();
    ct2_valid = 0; pix2_valid = 1; pix2_data = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d2_ov) begin d2.push_back(d2_out); l2.push_back(d2_last); end
      step();
    end
    pix2_valid = 0;
    chk("s40_n", d2.size(), 32);
    if (d2.size() == 32) begin
      chk("s40_first", d2[0], 8'h03);
      for (int i = 1; i < 32; i++) chk("s40_rest", d2[i], 8'h00);
      for (int i = 0; i < 32; i++) chk("s40_last", l2[i], i == 31);
    end
    chk("s40_blocks", d2_blocks, 1);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ct_valid = ($urandom % 4) == 0;
      ct_data = {$urandom, $urandom};
      pix_in_valid = ($urandom % 4) != 0;
      pix_in_data = 8'($urandom);
      pix_out_ready = ($urandom % 3) != 0;
      step();
    end
    ct_valid = 0; pix_in_valid = 1; pix_out_ready = 1;
    g = 0;
    while (busy && g < 200) begin step(); g++; end
    chk("rand_drain", busy, 0);
    pix_in_valid = 0;
    drain();
    chk("rand_blocks_seen", blocks_done > 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stego_lsb_embed.md
STEGO_LSB_EMBED -- requirements
Module: stego_lsb_embed

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter LSB_BITS, default 1, meaning ciphertext bits embedded per pixel; legal values are 1, 2 and 4.
REQ-003 Port clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  is the reset: asynchronous, active-high.
REQ-005 Port ct_data  in  64  is the ciphertext block, numbered [1:64]; bit 1 is the MSB and is embedded first.
REQ-006 Port ct_valid  in  1  indicates the upstream DES stage presents a ciphertext block.
REQ-007 Port ct_ready  out  1  indicates the block accepts the ciphertext block.
REQ-008 Port pix_in_data  in  PIX_W  is the cover-image pixel.
REQ-009 Port pix_in_valid  in  1 / pix_in_ready  out  1  form the cover-pixel handshake.
REQ-010 Port pix_out_data  out  PIX_W  is the stego pixel.
REQ-011 Port pix_out_valid  out  1 / pix_out_ready  in  1  form the stego-pixel handshake.
REQ-012 Port pix_out_last  out  1  flags the pixel carrying the final bits of a block.
REQ-013 Port busy  out  1  is high while a block is being embedded.
REQ-014 Port blocks_done  out  16  counts completed blocks.

Function
REQ-015 A transfer SHALL occur on any channel only in a cycle where valid and ready are both high.
REQ-016 The FSM SHALL have states IDLE and EMBED; busy = (state == EMBED).
REQ-017 In IDLE: ct_ready = 1, pix_in_ready = 0; a ct transfer latches ct_data into a 64-bit shift register, clears the pixel counter, and enters EMBED.
REQ-018 In EMBED: ct_ready = 0, except in the cycle the last pixel of the block is accepted on the input.
REQ-019 Pixels per block N = 64 / LSB_BITS; the pixel counter runs 0..N-1.
REQ-020 Merge rule: pix_out_data[PIX_W-1:LSB_BITS] = pix_in_data[PIX_W-1:LSB_BITS]; pix_out_data[LSB_BITS-1:0] = the next LSB_BITS ciphertext bits, with the earlier ciphertext bit at the higher position.
REQ-021 After each accepted pixel, the shift register SHALL advance by LSB_BITS.
REQ-022 The output stage SHALL be a single register with one-cycle latency from input transfer to pix_out_valid.
REQ-023 pix_in_ready (EMBED) = !pix_out_valid || pix_out_ready.
REQ-024 Under backpressure, pix_out_data, pix_out_valid and pix_out_last SHALL stay stable until transferred.
REQ-025 pix_out_last SHALL be high with the output pixel that came from input pixel index N-1.
REQ-026 On acceptance of input pixel N-1, the FSM SHALL return to IDLE.
REQ-027 If ct_valid is high in that same cycle, the new block SHALL be accepted immediately and the FSM SHALL stay in EMBED with the counter at 0, giving no bubble.
REQ-028 blocks_done SHALL increment on each output transfer with pix_out_last = 1, wrapping from 0xFFFF to 0x0000.
REQ-029 pix_in_valid low during EMBED SHALL stall the counter and shift register; no bits are lost or skipped.

Reset
REQ-030 While rst is high: state = IDLE; ct_ready = 0; pix_in_ready = 0; pix_out_valid = 0; pix_out_last = 0; pix_out_data = 0; busy = 0; blocks_done = 0; shift register and counter = 0.
REQ-031 Reset asserted mid-block SHALL discard the partial block, including any pending output pixel; the next accepted block starts at ciphertext bit 1.
REQ-032 After rst deasserts, ct_ready SHALL be 1 in IDLE.

Structure
REQ-033 Shared package stego_pkg SHALL hold CT_W = 64, the FSM state typedef, and the default PIX_W and LSB_BITS values.
REQ-034 The combinational merge of REQ-020 SHALL be a sub-module lsb_merge; the FSM, counter, shift register and output register SHALL live in stego_lsb_embed.

Verification
REQ-035 Scenario: ct = 0x0000000000000000, 64 pixels of 0xFF, pix_out_ready = 1 -> 64 outputs of 0xFE; last on output 64 only; blocks_done = 1.
REQ-036 Scenario: ct = 0x8000000000000001, pixels 0x00 -> output 0 = 0x01; outputs 1..62 = 0x00; output 63 = 0x01 with last = 1.
REQ-037 Scenario: ct = 0x85ABCD1A98876543, pixels 0xAA, pix_out_ready low for 5 cycles after pixel 10 -> outputs stable and pix_in_ready = 0 during the stall; LSB sequence 1,0,0,0,0,1,0,1,...; 64 outputs, none lost.
REQ-038 Scenario: two blocks, the second presented in the cycle pixel 63 of the first is accepted -> ct accepted that cycle; no idle output cycle between blocks; blocks_done = 2.
REQ-039 Scenario: rst pulsed after 10 output pixels -> all outputs zero, blocks_done = 0; a new block then embeds from bit 1.
REQ-040 Scenario: LSB_BITS = 2, ct = 0xC000000000000000, pixels 0x00 -> output 0 = 0x03; 32 outputs; last on output 32.
